upsample_nn2x: RTL and testbench

Nearest-neighbour 2x spatial up-sampler for the channel-serial feature-map stream used between decoder (deconv) layers. It buffers one input row of STRING_LEN pixels × CHANNEL_NUM channels in a ping-pong line buffer. When the row completes, it emits that row twice, repeating every pixel twice with all of its channels. Framing markers (sop/eop/sof/eof) are regenerated for the 2x geometry, so the next deconv layer sees a normal frame of width 2·STRING_LEN.

---
 rtl/upsample_nn2x.sv | 162 ++++++++++++++++
 tb/tb_upsample_nn2x.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/upsample_nn2x.sv
// Nearest-neighbour 2x up-sampler for channel-serial rows: buffers one row in a
// ping-pong line buffer and replays it twice with every pixel doubled.
module upsample_nn2x #(
   parameter int unsigned DATA_WIDTH  = 8,
   parameter int unsigned STRING_LEN  = 7,
   parameter int unsigned CHANNEL_NUM = 256
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [DATA_WIDTH-1:0] data_i,
   input  logic                  data_valid_i,
   input  logic                  sop_i,
   input  logic                  eop_i,
   input  logic                  sof_i,
   input  logic                  eof_i,
   output logic [DATA_WIDTH-1:0] data_o,
   output logic                  data_valid_o,
   output logic                  sop_o,
   output logic                  eop_o,
   output logic                  sof_o,
   output logic                  eof_o,
   output logic                  overflow_o,
   output logic                  len_err_o
);

   localparam int unsigned ROW_WORDS = STRING_LEN * CHANNEL_NUM;
   localparam int unsigned DEPTH     = 2 * ROW_WORDS;
   localparam int unsigned AW        = $clog2(DEPTH);
   localparam int unsigned WW        = $clog2(ROW_WORDS + 1);
   localparam int unsigned XW        = $clog2(2 * STRING_LEN);
   localparam int unsigned CW        = (CHANNEL_NUM > 1) ? $clog2(CHANNEL_NUM) : 1;

   localparam logic [AW-1:0] BANK_OFS = AW'(ROW_WORDS);
   localparam logic [AW-1:0] C_STRIDE = AW'(CHANNEL_NUM);
   localparam logic [WW-1:0] W_FULL   = WW'(ROW_WORDS);
   localparam logic [WW-1:0] W_LAST   = WW'(ROW_WORDS - 1);
   localparam logic [XW-1:0] X_LAST   = XW'(2 * STRING_LEN - 1);
   localparam logic [CW-1:0] C_LAST   = CW'(CHANNEL_NUM - 1);

   localparam logic [0:0] StIdle = 1'b0;
   localparam logic [0:0] StRead = 1'b1;

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   logic [0:0]    state;
   logic          wbank;
   logic          rbank;
   logic          row_sof;
   logic          rd_sof;
   logic          rd_eof;
   logic          rep;
   logic [XW-1:0] x;
   logic [CW-1:0] c;
   logic [WW-1:0] wcnt;
   logic [WW-1:0] widx;
   logic [WW-1:0] wnext;
   logic [AW-1:0] wr_addr;
   logic [AW-1:0] rd_addr;
   logic          wr_en;
   logic          eop_v;
   logic          rd_active;
   logic          at_sop;
   logic          at_eop;
   logic          last_addr;

   // wcnt saturates at ROW_WORDS so an over-long row is still flagged at eop.
   always_comb begin
      widx      = sop_i ? '0 : wcnt;
      wnext     = (widx == W_FULL) ? widx : widx + WW'(1);
      wr_en     = data_valid_i && (widx < W_FULL);
      wr_addr   = (wbank ? BANK_OFS : '0) + AW'(widx);
      eop_v     = data_valid_i && eop_i;
      rd_active = (state == StRead);
      at_sop    = (x == '0) && (c == '0);
      at_eop    = (x == X_LAST) && (c == C_LAST);
      last_addr = rep && at_eop;
      rd_addr   = (rbank ? BANK_OFS : '0) + AW'(x >> 1) * C_STRIDE + AW'(c);
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= data_i;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state      <= StIdle;
         wbank      <= 1'b0;
         rbank      <= 1'b0;
         wcnt       <= '0;
         row_sof    <= 1'b0;
         rd_sof     <= 1'b0;
         rd_eof     <= 1'b0;
         rep        <= 1'b0;
         x          <= '0;
         c          <= '0;
         overflow_o <= 1'b0;
         len_err_o  <= 1'b0;
      end else begin
         if (data_valid_i) begin
            wcnt <= wnext;
         end
         if (data_valid_i && sop_i) begin
            row_sof <= sof_i;
         end
         if (eop_v) begin
            if (widx != W_LAST) begin
               len_err_o <= 1'b1;
            end
            if (state == StIdle) begin
               rbank  <= wbank;
               wbank  <= ~wbank;
               state  <= StRead;
               rd_sof <= sop_i ? sof_i : row_sof;
               rd_eof <= eof_i;
            end else begin
               // Busy: the row is dropped and its bank is reused by the next row.
               overflow_o <= 1'b1;
            end
         end
         if (rd_active) begin
            if (c == C_LAST) begin
               c <= '0;
               if (x == X_LAST) begin
                  x   <= '0;
                  rep <= ~rep;
               end else begin
                  x <= x + XW'(1);
               end
            end else begin
               c <= c + CW'(1);
            end
            if (last_addr) begin
               state <= StIdle;
            end
         end
      end
   end

   // The RAM read register doubles as the output data register.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         data_o       <= '0;
         data_valid_o <= 1'b0;
         sop_o        <= 1'b0;
         eop_o        <= 1'b0;
         sof_o        <= 1'b0;
         eof_o        <= 1'b0;
      end else begin
         data_valid_o <= rd_active;
         sop_o        <= rd_active && at_sop;
         eop_o        <= rd_active && at_eop;
         sof_o        <= rd_active && at_sop && !rep && rd_sof;
         eof_o        <= rd_active && at_eop && rep && rd_eof;
         if (rd_active) begin
            data_o <= mem[rd_addr];
         end
      end
   end

endmodule

// File: tb/tb_upsample_nn2x.sv
// Scoreboard bench for upsample_nn2x: a small 2x2 instance for directed corner cases
// and a default-size instance for a full-width random stream.
module tb_upsample_nn2x;

   localparam int SL = 2;
   localparam int SC = 2;
   localparam int SN = SL * SC;
   localparam int FL = 7;
   localparam int FC = 256;
   localparam int FN = FL * FC;

   typedef struct {
      logic [7:0] d;
      logic [3:0] f;
      int         cyc;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_cmp = 0;
   int n_err = 0;

   exp_t q_s[$];
   exp_t q_f[$];
   exp_t es;
   exp_t ef;

   logic [7:0] sent [4];
   logic [7:0] rb_s [4];
   logic [7:0] rb_f [FN];

   logic       s_rst_n, s_vin, s_sop, s_eop, s_sof, s_eof;
   logic [7:0] s_din, s_dout;
   logic       s_vout, s_sopo, s_eopo, s_sofo, s_eofo, s_ovf, s_lerr;
   logic       f_rst_n, f_vin, f_sop, f_eop, f_sof, f_eof;
   logic [7:0] f_din, f_dout;
   logic       f_vout, f_sopo, f_eopo, f_sofo, f_eofo, f_ovf, f_lerr;

   upsample_nn2x #(.DATA_WIDTH(8), .STRING_LEN(SL), .CHANNEL_NUM(SC)) dut_s (
      .clk(clk), .reset_n(s_rst_n), .data_i(s_din), .data_valid_i(s_vin),
      .sop_i(s_sop), .eop_i(s_eop), .sof_i(s_sof), .eof_i(s_eof),
      .data_o(s_dout), .data_valid_o(s_vout), .sop_o(s_sopo), .eop_o(s_eopo),
      .sof_o(s_sofo), .eof_o(s_eofo), .overflow_o(s_ovf), .len_err_o(s_lerr)
   );

   upsample_nn2x dut_f (
      .clk(clk), .reset_n(f_rst_n), .data_i(f_din), .data_valid_i(f_vin),
      .sop_i(f_sop), .eop_i(f_eop), .sof_i(f_sof), .eof_i(f_eof),
      .data_o(f_dout), .data_valid_o(f_vout), .sop_o(f_sopo), .eop_o(f_eopo),
      .sof_o(f_sofo), .eof_o(f_eofo), .overflow_o(f_ovf), .len_err_o(f_lerr)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (edge %0d)", nm, act, req, cyc);
      end
   endtask

   // Expected nearest-neighbour replay of a row; word k is due after edge t+1+k.
   task automatic push_row(input bit big, input int t, input int n, input bit rsof,
                           input bit reof);
      int   len;
      int   ch;
      int   k;
      bit   sp;
      bit   ep;
      exp_t e;
      len = big ? FL : SL;
      ch  = big ? FC : SC;
      k   = 0;
      for (int rep = 0; rep < 2; rep++) begin
         for (int x = 0; x < 2 * len; x++) begin
            for (int c = 0; c < ch; c++) begin
               if (k < n) begin
                  sp    = (x == 0) && (c == 0);
                  ep    = (x == 2 * len - 1) && (c == ch - 1);
                  e.d   = big ? rb_f[(x / 2) * ch + c] : rb_s[(x / 2) * ch + c];
                  e.f   = {sp, ep, (rep == 0) && sp && rsof, (rep == 1) && ep && reof};
                  e.cyc = t + 1 + k;
                  if (big) q_f.push_back(e);
                  else q_s.push_back(e);
               end
               k++;
            end
         end
      end
   endtask

   task automatic wait_edge(input int e);
      while (cyc < e) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_s(input int n, input bit fsof, input bit feof, output int t);
      for (int i = 0; i < n; i++) begin
         s_din = sent[i];
         s_vin = 1'b1;
         s_sop = (i == 0);
         s_eop = (i == n - 1);
         s_sof = fsof && (i == 0);
         s_eof = feof && (i == n - 1);
         @(posedge clk);
         #1;
      end
      {s_vin, s_sop, s_eop, s_sof, s_eof} = '0;
      t = cyc;
   endtask

   always @(negedge clk) begin
      if (s_vout === 1'b1) begin
         if (q_s.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL s_spurious: valid word 0x%0h at edge %0d, none expected", s_dout, cyc);
         end else begin
            es = q_s.pop_front();
            chk("s_data", s_dout, es.d);
            chk("s_flags", {s_sopo, s_eopo, s_sofo, s_eofo}, es.f);
            chk("s_cycle", cyc, es.cyc);
         end
      end
      if (f_vout === 1'b1) begin
         if (q_f.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL f_spurious: valid word 0x%0h at edge %0d, none expected", f_dout, cyc);
         end else begin
            ef = q_f.pop_front();
            chk("f_data", f_dout, ef.d);
            chk("f_flags", {f_sopo, f_eopo, f_sofo, f_eofo}, ef.f);
            chk("f_cycle", cyc, ef.cyc);
         end
      end
   end

   task automatic run_small();
      int t;
      // Basic row
      sent = '{8'h10, 8'h11, 8'h20, 8'h21};
      rb_s = sent;
      send_s(4, 1'b0, 1'b0, t);
      push_row(1'b0, t, 4 * SN, 1'b0, 1'b0);
      // Two-row frame at minimum spacing
      sent = '{8'h30, 8'h31, 8'h40, 8'h41};
      wait_edge(t + 4 * SN + 1 - 4);
      send_s(4, 1'b1, 1'b0, t);
      rb_s = sent;
      push_row(1'b0, t, 4 * SN, 1'b1, 1'b0);
      sent = '{8'h50, 8'h51, 8'h60, 8'h61};
      wait_edge(t + 4 * SN + 1 - 4);
      send_s(4, 1'b0, 1'b1, t);
      rb_s = sent;
      push_row(1'b0, t, 4 * SN, 1'b0, 1'b1);
      chk("ovf_clear", s_ovf, 0);
      chk("lenerr_clear", s_lerr, 0);
      // Overflow: second eop ten edges after an accepted one
      sent = '{8'h70, 8'h71, 8'h80, 8'h81};
      wait_edge(t + 4 * SN + 1 - 4);
      send_s(4, 1'b0, 1'b0, t);
      rb_s = sent;
      push_row(1'b0, t, 4 * SN, 1'b0, 1'b0);
      wait_edge(t + 6);
      chk("ovf_before", s_ovf, 0);
      sent = '{8'h90, 8'h91, 8'ha0, 8'ha1};
      send_s(4, 1'b0, 1'b0, t);
      chk("ovf_set", s_ovf, 1);
      // Short row lands in the bank the dropped row wrote; last word is left over
      sent = '{8'hb0, 8'hb1, 8'hc0, 8'hee};
      wait_edge(t + 7 - 3);
      chk("lenerr_before", s_lerr, 0);
      send_s(3, 1'b0, 1'b0, t);
      chk("lenerr_set", s_lerr, 1);
      chk("ovf_sticky", s_ovf, 1);
      rb_s = '{8'hb0, 8'hb1, 8'hc0, 8'ha1};
      push_row(1'b0, t, 4 * SN, 1'b0, 1'b0);
      // Reset in the middle of a readout: only five words escape
      sent = '{8'hd0, 8'hd1, 8'he0, 8'he1};
      wait_edge(t + 4 * SN + 1 - 4);
      send_s(4, 1'b0, 1'b0, t);
      rb_s = sent;
      push_row(1'b0, t, 5, 1'b0, 1'b0);
      wait_edge(t + 5);
      s_rst_n = 1'b0;
      @(posedge clk);
      #1;
      s_rst_n = 1'b1;
      chk("midrst_valid", s_vout, 0);
      chk("midrst_data", s_dout, 0);
      chk("midrst_flags", {s_sopo, s_eopo, s_sofo, s_eofo}, 0);
      chk("midrst_ovf", s_ovf, 0);
      chk("midrst_lenerr", s_lerr, 0);
      wait_edge(cyc + 20);
      sent = '{8'hf0, 8'hf1, 8'ha2, 8'ha3};
      send_s(4, 1'b1, 1'b1, t);
      rb_s = sent;
      push_row(1'b0, t, 4 * SN, 1'b1, 1'b1);
      wait_edge(t + 4 * SN + 4);
   endtask

   task automatic run_full();
      int t;
      t = 0;
      for (int r = 0; r < 4; r++) begin
         if (r > 0) wait_edge(t + 3 * FN + 1);
         for (int i = 0; i < FN; i++) rb_f[i] = 8'($urandom);
         for (int i = 0; i < FN; i++) begin
            f_din = rb_f[i];
            f_vin = 1'b1;
            f_sop = (i == 0);
            f_eop = (i == FN - 1);
            f_sof = (r == 0) && (i == 0);
            f_eof = (r == 3) && (i == FN - 1);
            @(posedge clk);
            #1;
         end
         {f_vin, f_sop, f_eop, f_sof, f_eof} = '0;
         t = cyc;
         push_row(1'b1, t, 4 * FN, r == 0, r == 3);
      end
      wait_edge(t + 4 * FN + 2);
      chk("f_overflow", f_ovf, 0);
      chk("f_len_err", f_lerr, 0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      s_rst_n = 1'b0;
      f_rst_n = 1'b0;
      s_din   = '0;
      f_din   = '0;
      {s_vin, s_sop, s_eop, s_sof, s_eof} = '0;
      {f_vin, f_sop, f_eop, f_sof, f_eof} = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_valid", s_vout, 0);
      chk("reset_data", s_dout, 0);
      chk("reset_flags", {s_sopo, s_eopo, s_sofo, s_eofo}, 0);
      chk("reset_ovf", s_ovf, 0);
      chk("reset_lenerr", s_lerr, 0);
      chk("reset_f_valid", f_vout, 0);
      s_rst_n = 1'b1;
      f_rst_n = 1'b1;
      fork
         run_small();
         run_full();
      join
      chk("s_queue_drained", q_s.size(), 0);
      chk("f_queue_drained", q_f.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
